// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader state encoding and stream framing constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      PAYLOAD,
      CHECK,
      DONE,
      ERROR
   } state_t;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte stream plus imem write port bundled for the loader.
interface imem_loader_if;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport master (output s_valid, s_data, input s_ready, imem_we, imem_addr, imem_wdata);
   modport slave  (input s_valid, s_data, output s_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_to_word_packer.sv
// rtl/imem_loader_byte_to_word_packer.sv - little-endian byte to 32-bit word assembler.
// Emits a one-cycle word_valid_o the cycle after the fourth byte of a word is taken.
module imem_loader_byte_to_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);
   logic [1:0]  lane_q, lane_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] word_q, word_d;
   logic        valid_q, valid_d;

   always_comb begin
      lane_d  = lane_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (byte_valid_i) begin
         // Shifting in from the top leaves the first byte in [7:0] after four bytes.
         shift_d = {byte_data_i, shift_q[31:8]};
         lane_d  = lane_q + 2'd1;
         if (lane_q == 2'(BYTES_PER_WORD - 1)) begin
            word_d  = shift_d;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q  <= '0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         lane_q  <= lane_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign word_valid_o = valid_q;
   assign word_o       = word_q;
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed program into imem, then releases core reset.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte checked in CHECK before DONE.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LEN_W       = 16
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  start,
   imem_loader_if.slave bus,
   output logic  core_reset,
   output logic  busy,
   output logic  done,
   output logic  error
);
   localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(DEPTH_WORDS);

   state_t           state_q, state_d;
   logic [7:0]       len_lo_q, len_lo_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] word_idx_q, word_idx_d;
   logic [LEN_W+1:0] byte_cnt_q, byte_cnt_d;
   logic [LEN_W-1:0] hdr_len;
   logic             accept;
   logic             word_valid;
   logic [31:0]      word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] xor_q, xor_d;
   localparam state_t PAYLOAD_END = CHECK;
`else
   localparam state_t PAYLOAD_END = DONE;
`endif

   assign busy        = state_q inside {LEN_LO, LEN_HI, PAYLOAD, CHECK};
   assign done        = (state_q == DONE);
   assign error       = (state_q == ERROR);
   assign core_reset  = ~done;
   assign bus.s_ready = busy;
   assign accept      = bus.s_valid & bus.s_ready;
   assign hdr_len     = LEN_W'({bus.s_data, len_lo_q});

   imem_loader_byte_to_word_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .byte_valid_i (accept && (state_q == PAYLOAD)),
      .byte_data_i  (bus.s_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   // word_idx_q still names the word being strobed; it advances on the strobe itself.
   assign bus.imem_we    = word_valid;
   assign bus.imem_wdata = word;
   assign bus.imem_addr  = BASE_ADDR + 32'({word_idx_q, 2'b00});

   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      word_idx_d = word_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d      = xor_q;
`endif
      if (word_valid) word_idx_d = word_idx_q + LEN_W'(1);
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d    = LEN_LO;
               byte_cnt_d = '0;
               word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d      = '0;
`endif
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_lo_d = bus.s_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d = hdr_len;
               if ({1'b0, hdr_len} > MAX_WORDS) state_d = ERROR;
               else if (hdr_len == '0)          state_d = PAYLOAD_END;
               else                             state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + (LEN_W + 2)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d      = xor_q ^ bus.s_data;
`endif
               if (byte_cnt_d == {len_q, 2'b00}) state_d = PAYLOAD_END;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) state_d = (bus.s_data == xor_q) ? DONE : ERROR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         len_lo_q   <= '0;
         len_q      <= '0;
         byte_cnt_q <= '0;
         word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         len_q      <= len_d;
         byte_cnt_q <= byte_cnt_d;
         word_idx_q <= word_idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a word-list model.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 256;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic core_reset, busy, done, error;

   imem_loader_if bus ();

   imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LEN_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .core_reset (core_reset),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] obs_q[$];
   logic [31:0] wbuf[0:DEPTH];

   always @(negedge clk) if (bus.imem_we === 1'b1) obs_q.push_back({bus.imem_addr, bus.imem_wdata});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max, input bit noise);
      int g;
      bit acc;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      bus.s_valid = 1'b0;
      for (int i = 0; i < g; i++) begin
         start = noise && ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
      end
      start = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         if (bus.s_ready === 1'b1) acc = 1'b1;
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   // Model: word j lives at BASE+4j, bytes sent least significant first.
   task automatic run_load(input int n, input int gap, input bit noise, input bit good_sum, input string tag);
      logic [7:0] x;
      logic [15:0] hdr;
      x = 8'h00;
      hdr = 16'(n);
      obs_q.delete();
      bus.s_valid = 1'b1;
      bus.s_data  = hdr[7:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_byte(hdr[7:0], gap, 1'b0);
      send_byte(hdr[15:8], gap, 1'b0);
      if (n <= DEPTH) begin
         for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 4; k++) begin
               x ^= wbuf[j][8*k +: 8];
               send_byte(wbuf[j][8*k +: 8], gap, noise);
            end
         end
      end
      @(negedge clk);
      if (n > DEPTH) begin
         chk({tag, "_error"}, 64'(error), 64'd1);
         chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
         chk({tag, "_busy"}, 64'(busy), 64'd0);
         chk({tag, "_no_we"}, 64'(obs_q.size()), 64'd0);
         return;
      end
      if (n > 0) begin
         chk({tag, "_last_we"}, 64'(bus.imem_we), 64'd1);
         chk({tag, "_last_addr"}, 64'(bus.imem_addr), 64'(BASE + 32'(4 * (n - 1))));
         chk({tag, "_last_data"}, 64'(bus.imem_wdata), 64'(wbuf[n-1]));
      end else begin
         chk({tag, "_no_we"}, 64'(bus.imem_we), 64'd0);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk({tag, "_check_busy"}, 64'(busy), 64'd1);
      chk({tag, "_check_core_reset"}, 64'(core_reset), 64'd1);
      send_byte(good_sum ? x : (x ^ 8'h01), gap, 1'b0);
      @(negedge clk);
      chk({tag, "_done"}, 64'(done), 64'(good_sum));
      chk({tag, "_err"}, 64'(error), 64'(!good_sum));
      chk({tag, "_core_reset"}, 64'(core_reset), 64'(!good_sum));
`else
      chk({tag, "_done"}, 64'(done), 64'(good_sum));
      chk({tag, "_core_reset"}, 64'(core_reset), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
`endif
      @(negedge clk);
      chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(n));
      for (int j = 0; j < n && j < obs_q.size(); j++)
         chk($sformatf("%s_w%0d", tag, j), obs_q[j], {BASE + 32'(4 * j), wbuf[j]});
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
      chk("rst_we", 64'(bus.imem_we), 64'd0);
      chk("rst_addr", 64'(bus.imem_addr), 64'(BASE));
      chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
      chk("rst_core_reset", 64'(core_reset), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      wbuf[0] = 32'h00A0_0513;
      wbuf[1] = 32'h00B0_0593;
      run_load(2, 0, 1'b0, 1'b1, "spec");

      run_load(0, 0, 1'b0, 1'b1, "empty");

      run_load(DEPTH + 1, 0, 1'b0, 1'b1, "oversize");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("recover_busy", 64'(busy), 64'd1);
      chk("recover_s_ready", 64'(bus.s_ready), 64'd1);
      chk("recover_error", 64'(error), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      for (int j = 0; j < DEPTH; j++) wbuf[j] = $urandom;
      run_load(DEPTH, 2, 1'b1, 1'b1, "full");

      for (int j = 0; j < 3; j++) wbuf[j] = $urandom;
      obs_q.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_byte(8'd3, 0, 1'b0);
      send_byte(8'd0, 0, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(wbuf[i / 4][8 * (i % 4) +: 8], 1, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_core_reset", 64'(core_reset), 64'd1);
      chk("midrst_s_ready", 64'(bus.s_ready), 64'd0);
      chk("midrst_nwrites", 64'(obs_q.size()), 64'd1);
      if (obs_q.size() > 0) chk("midrst_w0", obs_q[0], {BASE, wbuf[0]});
      @(posedge clk); #1;
      run_load(3, 1, 1'b0, 1'b1, "reload");

      for (int j = 0; j < 7; j++) wbuf[j] = $urandom;
`ifdef IMEM_LOADER_CHECKSUM_EN
      run_load(7, 1, 1'b1, 1'b0, "badsum");
      run_load(7, 0, 1'b0, 1'b1, "goodsum");
`else
      run_load(7, 3, 1'b1, 1'b1, "gappy");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
